// File: rtl/uart_cmd_parser.sv
// ASCII command-line parser: "R|W aaaaaaaa ll CR" lines from the UART receiver become
// card_driver read/write requests; write payload bytes are forwarded over WD.
module uart_cmd_parser #(
    parameter int BLOCK_BYTES    = 512,
    parameter int TIMEOUT_CYCLES = 50_000_000
) (
    input  logic        CLOCK50,
    input  logic        RESET,
    input  logic        RX_STB,
    input  logic [7:0]  RX_DAT,
    output logic        WR_STB,
    output logic [31:0] WR_ADDR,
    output logic [7:0]  WR_LENGTH,
    input  logic        WR_ACK,
    output logic        RD_STB,
    output logic [31:0] RD_ADDR,
    output logic [7:0]  RD_LENGTH,
    input  logic        RD_ACK,
    output logic        WD_STB,
    output logic [7:0]  WD_DATA,
    input  logic        WD_ACK,
    output logic        BUSY,
    output logic        ERR_STB,
    output logic [2:0]  ERR_CODE,
    output logic [2:0]  dbg_state_o
);

    // Handshakes: each *_STB is held with its data stable until the matching *_ACK is
    // sampled high on a rising edge; the STB is low in the following cycle. ACK while
    // STB is low is ignored. RX_STB is a bare strobe and cannot be stalled.

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_ADDR = 3'd1,
        S_LEN  = 3'd2,
        S_EOL  = 3'd3,
        S_RREQ = 3'd4,
        S_DATA = 3'd5
    } state_t;

    localparam int TMO_W = $clog2(TIMEOUT_CYCLES);
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);

    state_t      state_q, state_d;
    logic        is_wr_q, is_wr_d;
    logic [31:0] addr_q, addr_d;
    logic [7:0]  len_q, len_d;
    logic [2:0]  dig_q, dig_d;
    logic        rd_stb_q, rd_stb_d;
    logic        wr_stb_q, wr_stb_d;
    logic [31:0] wr_addr_q, wr_addr_d;
    logic [7:0]  wr_len_q, wr_len_d;
    logic        wd_stb_q, wd_stb_d;
    logic [7:0]  wd_data_q, wd_data_d;
    logic [16:0] byte_cnt_q, byte_cnt_d;
    logic [TMO_W-1:0] tmo_q, tmo_d;
    logic        err_stb_q, err_stb_d;
    logic [2:0]  err_code_q, err_code_d;

    logic        err_set;
    logic [2:0]  err_val;
    logic        tmo_run;
    logic [4:0]  hx;
    logic [16:0] byte_target;

    // Returns {valid, nibble} for an ASCII hex digit in either case.
    function automatic logic [4:0] hex_nib(input logic [7:0] c);
        hex_nib = 5'b0;
        if (c >= 8'h30 && c <= 8'h39)      hex_nib = {1'b1, 4'(c - 8'h30)};
        else if (c >= 8'h41 && c <= 8'h46) hex_nib = {1'b1, 4'(c - 8'h37)};
        else if (c >= 8'h61 && c <= 8'h66) hex_nib = {1'b1, 4'(c - 8'h57)};
    endfunction

    assign hx          = hex_nib(RX_DAT);
    assign byte_target = 17'(wr_len_q) * 17'(BLOCK_BYTES);
    assign tmo_run     = (state_q == S_ADDR) || (state_q == S_LEN) ||
                         (state_q == S_EOL)  || (state_q == S_DATA);

    always_comb begin
        state_d    = state_q;
        is_wr_d    = is_wr_q;
        addr_d     = addr_q;
        len_d      = len_q;
        dig_d      = dig_q;
        rd_stb_d   = rd_stb_q;
        wr_stb_d   = wr_stb_q & ~WR_ACK;
        wr_addr_d  = wr_addr_q;
        wr_len_d   = wr_len_q;
        wd_stb_d   = wd_stb_q & ~WD_ACK;
        wd_data_d  = wd_data_q;
        byte_cnt_d = byte_cnt_q;
        err_stb_d  = 1'b0;
        err_code_d = err_code_q;
        err_set    = 1'b0;
        err_val    = 3'd0;
        // Counter holds the number of cycles elapsed since the last received byte.
        tmo_d      = RX_STB ? TMO_W'(1) : (tmo_run ? tmo_q + TMO_W'(1) : '0);

        case (state_q)
            S_IDLE: begin
                if (RX_STB) begin
                    if (RX_DAT == 8'h0A || RX_DAT == 8'h0D || RX_DAT == 8'h20) begin
                        state_d = S_IDLE;
                    end else if (RX_DAT == 8'h52 || RX_DAT == 8'h72) begin
                        is_wr_d = 1'b0;
                        dig_d   = 3'd0;
                        state_d = S_ADDR;
                    end else if (RX_DAT == 8'h57 || RX_DAT == 8'h77) begin
                        is_wr_d = 1'b1;
                        dig_d   = 3'd0;
                        state_d = S_ADDR;
                    end else begin
                        err_set = 1'b1;
                        err_val = 3'd1;
                    end
                end
            end
            S_ADDR: begin
                if (RX_STB) begin
                    if (hx[4]) begin
                        addr_d = {addr_q[27:0], hx[3:0]};
                        dig_d  = dig_q + 3'd1;
                        if (dig_q == 3'd7) begin
                            dig_d   = 3'd0;
                            state_d = S_LEN;
                        end
                    end else begin
                        err_set = 1'b1;
                        err_val = 3'd1;
                    end
                end
            end
            S_LEN: begin
                if (RX_STB) begin
                    if (hx[4]) begin
                        len_d = {len_q[3:0], hx[3:0]};
                        dig_d = dig_q + 3'd1;
                        if (dig_q == 3'd1) state_d = S_EOL;
                    end else begin
                        err_set = 1'b1;
                        err_val = 3'd1;
                    end
                end
            end
            S_EOL: begin
                if (RX_STB) begin
                    if (RX_DAT != 8'h0D) begin
                        err_set = 1'b1;
                        err_val = 3'd1;
                    end else if (len_q == 8'd0) begin
                        err_set = 1'b1;
                        err_val = 3'd2;
                    end else if (is_wr_q) begin
                        wr_stb_d   = 1'b1;
                        wr_addr_d  = addr_q;
                        wr_len_d   = len_q;
                        byte_cnt_d = '0;
                        state_d    = S_DATA;
                    end else begin
                        rd_stb_d = 1'b1;
                        state_d  = S_RREQ;
                    end
                end
            end
            S_RREQ: begin
                if (RD_ACK) begin
                    rd_stb_d = 1'b0;
                    state_d  = S_IDLE;
                end
            end
            S_DATA: begin
                if (RX_STB && wd_stb_q && !WD_ACK) begin
                    err_set = 1'b1;
                    err_val = 3'd3;
                end else begin
                    // Bytes beyond the announced length are dropped.
                    if (RX_STB && byte_cnt_q != byte_target) begin
                        wd_data_d  = RX_DAT;
                        wd_stb_d   = 1'b1;
                        byte_cnt_d = byte_cnt_q + 17'd1;
                    end
                    if (byte_cnt_q == byte_target && !wd_stb_d && !wr_stb_d) begin
                        state_d = S_IDLE;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase

        if (tmo_run && !RX_STB && tmo_q == TMO_LAST) begin
            err_set = 1'b1;
            err_val = 3'd4;
        end

        // A pending write request survives an error; only the payload path is dropped.
        if (err_set) begin
            state_d    = S_IDLE;
            err_stb_d  = 1'b1;
            err_code_d = err_val;
            wd_stb_d   = 1'b0;
        end
    end

    always_ff @(posedge CLOCK50 or posedge RESET) begin
        if (RESET) begin
            state_q    <= S_IDLE;
            is_wr_q    <= 1'b0;
            addr_q     <= '0;
            len_q      <= '0;
            dig_q      <= '0;
            rd_stb_q   <= 1'b0;
            wr_stb_q   <= 1'b0;
            wr_addr_q  <= '0;
            wr_len_q   <= '0;
            wd_stb_q   <= 1'b0;
            wd_data_q  <= '0;
            byte_cnt_q <= '0;
            tmo_q      <= '0;
            err_stb_q  <= 1'b0;
            err_code_q <= '0;
        end else begin
            state_q    <= state_d;
            is_wr_q    <= is_wr_d;
            addr_q     <= addr_d;
            len_q      <= len_d;
            dig_q      <= dig_d;
            rd_stb_q   <= rd_stb_d;
            wr_stb_q   <= wr_stb_d;
            wr_addr_q  <= wr_addr_d;
            wr_len_q   <= wr_len_d;
            wd_stb_q   <= wd_stb_d;
            wd_data_q  <= wd_data_d;
            byte_cnt_q <= byte_cnt_d;
            tmo_q      <= tmo_d;
            err_stb_q  <= err_stb_d;
            err_code_q <= err_code_d;
        end
    end

    assign RD_STB      = rd_stb_q;
    assign RD_ADDR     = addr_q;
    assign RD_LENGTH   = len_q;
    assign WR_STB      = wr_stb_q;
    assign WR_ADDR     = wr_addr_q;
    assign WR_LENGTH   = wr_len_q;
    assign WD_STB      = wd_stb_q;
    assign WD_DATA     = wd_data_q;
    assign BUSY        = (state_q != S_IDLE);
    assign ERR_STB     = err_stb_q;
    assign ERR_CODE    = err_code_q;
    assign dbg_state_o = state_q;

endmodule
